// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the reaction-timer game: start detection, random pre-delay,
// timing-block enable, hit/false-start/timeout resolution and score bookkeeping.
module reaction_round_ctrl #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_n,
    input  logic [9:0]  SW,
    input  logic [3:0]  hit_state,
    input  logic [15:0] score_in,
    output logic        timing_en,
    output logic [3:0]  state,
    output logic [15:0] last_score,
    output logic [15:0] best_score,
    output logic        new_best
);

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StDelay      = 4'd1,
        StTiming     = 4'd2,
        StResult     = 4'd3,
        StFalseStart = 4'd4,
        StTimeout    = 4'd5,
        StCapture    = 4'd6
    } state_e;

    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
    localparam logic [15:0]   MinDelay  = 16'(MIN_DELAY_MS);
    localparam logic [15:0]   TimeoutMs = 16'(TIMEOUT_MS);
    localparam logic [7:0]    LfsrTaps  = 8'hB8;
    localparam logic [3:0]    HitCode   = 4'd3;
    localparam logic [15:0]   ScoreMax  = 16'h9999;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q, sync_prev_q, press_q;
    logic          press, sw_active, tick;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_cnt_q, ms_cnt_d, ms_next;
    logic [15:0]   delay_ms_q, delay_ms_d;
    logic          cap_q, cap_d;
    logic          timing_en_q;
    logic [15:0]   last_q, last_d;
    logic [15:0]   best_q, best_d;
    logic          new_best_q, new_best_d;

    assign sw_active = |SW;
    // Presses made while a switch is already held never start a round.
    assign press     = press_q & ~sw_active;
    assign tick      = (presc_q == PrescLast);
    assign ms_next   = ms_cnt_q + 16'd1;
    assign lfsr_d    = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LfsrTaps : 8'h00);

    always_comb begin
        state_d    = state_q;
        presc_d    = tick ? '0 : presc_q + PW'(1);
        ms_cnt_d   = ms_cnt_q;
        delay_ms_d = delay_ms_q;
        cap_d      = cap_q;
        last_d     = last_q;
        best_d     = best_q;
        new_best_d = new_best_q;

        unique case (state_q)
            StIdle, StResult, StFalseStart, StTimeout: begin
                if (press) begin
                    state_d    = StDelay;
                    delay_ms_d = MinDelay + {5'b0, lfsr_q, 3'b000};
                    ms_cnt_d   = '0;
                    presc_d    = '0;
                    new_best_d = 1'b0;
                end
            end
            StDelay: begin
                if (sw_active) begin
                    state_d = StFalseStart;
                    last_d  = '0;
                end else if (tick) begin
                    if (ms_next == delay_ms_q) begin
                        state_d  = StTiming;
                        ms_cnt_d = '0;
                        presc_d  = '0;
                    end else begin
                        ms_cnt_d = ms_next;
                    end
                end
            end
            StTiming: begin
                if (hit_state == HitCode) begin
                    state_d = StCapture;
                    cap_d   = 1'b0;
                end else if (tick) begin
                    if (ms_next == TimeoutMs) begin
                        state_d = StTimeout;
                        last_d  = ScoreMax;
                    end else begin
                        ms_cnt_d = ms_next;
                    end
                end
            end
            StCapture: begin
                // Second cycle: the timing block has latched its score on en falling.
                if (cap_q) begin
                    state_d = StResult;
                    last_d  = score_in;
                    if (score_in < best_q) begin
                        best_d     = score_in;
                        new_best_d = 1'b1;
                    end
                end else begin
                    cap_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            press_q     <= 1'b0;
            lfsr_q      <= 8'h01;
            presc_q     <= '0;
            ms_cnt_q    <= '0;
            delay_ms_q  <= '0;
            cap_q       <= 1'b0;
            state_q     <= StIdle;
            timing_en_q <= 1'b0;
            last_q      <= '0;
            best_q      <= ScoreMax;
            new_best_q  <= 1'b0;
        end else begin
            sync1_q     <= start_n;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            press_q     <= sync_prev_q & ~sync2_q;
            lfsr_q      <= lfsr_d;
            presc_q     <= presc_d;
            ms_cnt_q    <= ms_cnt_d;
            delay_ms_q  <= delay_ms_d;
            cap_q       <= cap_d;
            state_q     <= state_d;
            timing_en_q <= (state_d == StTiming);
            last_q      <= last_d;
            best_q      <= best_d;
            new_best_q  <= new_best_d;
        end
    end

    assign timing_en  = timing_en_q;
    assign state      = state_q;
    assign last_score = last_q;
    assign best_score = best_q;
    assign new_best   = new_best_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Randomized round-level bench for reaction_round_ctrl; expectations come from a
// round-outcome model (delay formula, min-tracking best score, fixed latencies).
module tb_reaction_round_ctrl;

    localparam int unsigned TickDiv   = 4;
    localparam int unsigned MinDelay  = 2;
    localparam int unsigned TimeoutMs = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_n = 1'b1;
    logic [9:0]  sw = '0;
    logic [3:0]  hit_state = '0;
    logic [15:0] score_in = '0;
    logic        timing_en;
    logic [3:0]  state;
    logic [15:0] last_score;
    logic [15:0] best_score;
    logic        new_best;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_lfsr, m_lfsr_prev;
    logic [15:0] m_best;
    logic [15:0] m_last;
    int          exp_state;

    reaction_round_ctrl #(
        .TICK_DIV    (TickDiv),
        .MIN_DELAY_MS(MinDelay),
        .TIMEOUT_MS  (TimeoutMs)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_n   (start_n),
        .SW        (sw),
        .hit_state (hit_state),
        .score_in  (score_in),
        .timing_en (timing_en),
        .state     (state),
        .last_score(last_score),
        .best_score(best_score),
        .new_best  (new_best)
    );

    always #5 clk = ~clk;

    // Galois LFSR for x^8+x^6+x^5+x^4+1, seeded by reset, one step per clock.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic fb;
        fb = v[0];
        v  = v >> 1;
        if (fb) v = v ^ 8'b1011_1000;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr      <= 8'h01;
            m_lfsr_prev <= 8'h01;
        end else begin
            m_lfsr_prev <= m_lfsr;
            m_lfsr      <= lfsr_next(m_lfsr);
        end
    end

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Press from a resting state; returns the DELAY length in clk cycles.
    task automatic press_to_delay(output int d_cycles);
        int lval;
        @(negedge clk) start_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("press_latency_hold", 32'(state), 32'(exp_state));
        @(negedge clk);
        check_eq("delay_entry_state", 32'(state), 32'd1);
        check_eq("delay_entry_en", 32'(timing_en), 32'd0);
        check_eq("delay_entry_new_best", 32'(new_best), 32'd0);
        lval     = int'(m_lfsr_prev);
        d_cycles = int'((MinDelay + 8 * lval) * TickDiv);
        start_n  = 1'b1;
        exp_state = 1;
    endtask

    task automatic run_delay(input int d_cycles);
        repeat (d_cycles - 1) @(negedge clk);
        check_eq("delay_last_cycle_state", 32'(state), 32'd1);
        check_eq("delay_last_cycle_en", 32'(timing_en), 32'd0);
        @(negedge clk);
        check_eq("timing_entry_state", 32'(state), 32'd2);
        check_eq("timing_entry_en", 32'(timing_en), 32'd1);
        exp_state = 2;
    endtask

    task automatic do_hit(input int h, input logic [15:0] s);
        logic exp_nb;
        repeat (h) @(negedge clk);
        hit_state = 4'd3;
        score_in  = s;
        @(negedge clk);
        check_eq("hit_capture_state", 32'(state), 32'd6);
        check_eq("hit_en_low", 32'(timing_en), 32'd0);
        hit_state = 4'd0;
        @(negedge clk);
        check_eq("capture_hold_state", 32'(state), 32'd6);
        @(negedge clk);
        exp_nb = (s < m_best);
        if (exp_nb) m_best = s;
        m_last = s;
        check_eq("result_state", 32'(state), 32'd3);
        check_eq("result_last", 32'(last_score), 32'(m_last));
        check_eq("result_best", 32'(best_score), 32'(m_best));
        check_eq("result_new_best", 32'(new_best), 32'(exp_nb));
        check_eq("result_en", 32'(timing_en), 32'd0);
        exp_state = 3;
    endtask

    task automatic do_timeout();
        repeat (TimeoutMs * TickDiv - 1) @(negedge clk);
        check_eq("timing_before_expiry", 32'(state), 32'd2);
        @(negedge clk);
        m_last = 16'h9999;
        check_eq("timeout_state", 32'(state), 32'd5);
        check_eq("timeout_last", 32'(last_score), 32'(m_last));
        check_eq("timeout_best", 32'(best_score), 32'(m_best));
        check_eq("timeout_en", 32'(timing_en), 32'd0);
        check_eq("timeout_new_best", 32'(new_best), 32'd0);
        exp_state = 5;
    endtask

    // r cycles into DELAY the switch is raised; r == d_cycles lands on the expiring tick.
    task automatic do_false_start(input int r);
        repeat (r - 1) @(negedge clk);
        check_eq("pre_false_en", 32'(timing_en), 32'd0);
        sw = 10'($urandom_range(1, 1023));
        @(negedge clk);
        m_last = 16'h0000;
        check_eq("false_state", 32'(state), 32'd4);
        check_eq("false_last", 32'(last_score), 32'(m_last));
        check_eq("false_best", 32'(best_score), 32'(m_best));
        check_eq("false_en", 32'(timing_en), 32'd0);
        start_n = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("gated_press_ignored", 32'(state), 32'd4);
        check_eq("gated_press_en", 32'(timing_en), 32'd0);
        start_n = 1'b1;
        repeat (4) @(negedge clk);
        sw = '0;
        repeat (2) @(negedge clk);
        check_eq("false_after_release", 32'(state), 32'd4);
        exp_state = 4;
    endtask

    task automatic do_reset_in_timing(input int h);
        repeat (h) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        m_best = 16'h9999;
        m_last = 16'h0000;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_en", 32'(timing_en), 32'd0);
        check_eq("rst_best", 32'(best_score), 32'(m_best));
        check_eq("rst_last", 32'(last_score), 32'(m_last));
        check_eq("rst_new_best", 32'(new_best), 32'd0);
        exp_state = 0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int d;
        int kind;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        m_best    = 16'h9999;
        m_last    = 16'h0000;
        exp_state = 0;
        check_eq("reset_state", 32'(state), 32'd0);
        check_eq("reset_en", 32'(timing_en), 32'd0);
        check_eq("reset_best", 32'(best_score), 32'(m_best));
        check_eq("reset_last", 32'(last_score), 32'(m_last));
        check_eq("reset_new_best", 32'(new_best), 32'd0);

        press_to_delay(d); run_delay(d); do_hit($urandom_range(0, 79), 16'h0123);
        press_to_delay(d); run_delay(d); do_hit($urandom_range(0, 79), 16'h0123);
        press_to_delay(d); run_delay(d); do_hit($urandom_range(0, 79), 16'h0456);
        press_to_delay(d); do_false_start($urandom_range(1, d));
        press_to_delay(d); run_delay(d); do_timeout();
        press_to_delay(d); run_delay(d); do_hit(TimeoutMs * TickDiv - 1, rand_bcd());
        press_to_delay(d); run_delay(d); do_reset_in_timing($urandom_range(0, 70));

        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            kind = int'($urandom_range(0, 3));
            press_to_delay(d);
            if (kind == 0) begin
                do_false_start(($urandom_range(0, 1) == 1) ? d : int'($urandom_range(1, d)));
            end else begin
                run_delay(d);
                if (kind == 1) do_timeout();
                else do_hit($urandom_range(0, 79), rand_bcd());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
